xadc_drp_sampler: RTL and testbench

Upstream stage between the XADC wizard DRP port and the display/LED datapath. It turns each XADC end-of-conversion pulse into a single DRP read and captures the 12-bit result. It block-averages 2^AVG_LOG2 samples into a left-aligned 16-bit value, then scales that value to a display integer. Outputs feed the binary/BCD display mux and the LED bar.

---
 rtl/xadc_drp_sampler.sv | 136 +++++++++++++
 tb/tb_xadc_drp_sampler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_sampler.sv
// XADC DRP sampler: one DRP read per end-of-conversion, block average, scale.
// Ports: clk/reset, eoc_in, drdy_in, do_in -> den_out, daddr_out, raw_sample,
//   sample_valid, ave_data, scaled_data, ave_valid, timeout_err.
module xadc_drp_sampler #(
  parameter int         AVG_LOG2       = 4,
  parameter int         SCALE_MULT     = 1000,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [6:0] CHANNEL_ADDR   = 7'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eoc_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        den_out,
  output logic [6:0]  daddr_out,
  output logic [11:0] raw_sample,
  output logic        sample_valid,
  output logic [15:0] ave_data,
  output logic [15:0] scaled_data,
  output logic        ave_valid,
  output logic        timeout_err
);

  localparam int ACC_W = 12 + AVG_LOG2;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state, state_nxt;

  logic                issue;
  logic                take;
  logic                expire;
  logic [15:0]         tcnt;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W+3:0]    acc_sh;
  logic [AVG_LOG2-1:0] cnt;
  logic                blk_done;
  logic [11:0]         sample;
  logic [31:0]         prod;
  logic                unused_bits;

  assign daddr_out   = CHANNEL_ADDR;
  assign sample      = do_in[15:4];
  assign acc_sum     = acc + ACC_W'(sample);
  // Left-align to 16 bits, then divide by the block size.
  assign acc_sh      = {acc_sum, 4'b0000};
  assign prod        = 32'(ave_data) * 32'(SCALE_MULT);
  assign unused_bits = ^{do_in[3:0], prod[15:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    take      = 1'b0;
    expire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (eoc_in) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A drdy on the timeout edge wins over the timeout.
        if (drdy_in) begin
          take      = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt == 16'(TIMEOUT_CYCLES)) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      den_out      <= 1'b0;
      raw_sample   <= '0;
      sample_valid <= 1'b0;
      ave_data     <= '0;
      scaled_data  <= '0;
      ave_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      tcnt         <= '0;
      acc          <= '0;
      cnt          <= '0;
      blk_done     <= 1'b0;
    end else begin
      den_out      <= issue;
      sample_valid <= take;
      ave_valid    <= blk_done;
      blk_done     <= 1'b0;

      if (issue) begin
        tcnt <= 16'd1;
      end else if (state == WAIT && !take && !expire) begin
        tcnt <= tcnt + 16'd1;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end

      if (take) begin
        raw_sample <= sample;
        if (&cnt) begin
          ave_data <= acc_sh[AVG_LOG2 +: 16];
          acc      <= '0;
          cnt      <= '0;
          blk_done <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + AVG_LOG2'(1);
        end
      end

      if (blk_done) begin
        scaled_data <= prod[31:16];
      end
    end
  end

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Self-checking bench for xadc_drp_sampler: per-cycle model compare plus
// directed literal checks and a randomized read phase.
module tb_xadc_drp_sampler;

  localparam int L  = 4;
  localparam int SM = 1000;
  localparam int TO = 255;

  logic        clk;
  logic        reset;
  logic        eoc_in;
  logic        drdy_in;
  logic [15:0] do_in;
  logic        den_out;
  logic [6:0]  daddr_out;
  logic [11:0] raw_sample;
  logic        sample_valid;
  logic [15:0] ave_data;
  logic [15:0] scaled_data;
  logic        ave_valid;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int den_cnt = 0;
  int av_cnt = 0;
  int sv_cnt = 0;

  xadc_drp_sampler #(
    .AVG_LOG2(L), .SCALE_MULT(SM), .TIMEOUT_CYCLES(TO), .CHANNEL_ADDR(7'h1F)
  ) dut (
    .clk(clk), .reset(reset), .eoc_in(eoc_in), .drdy_in(drdy_in),
    .do_in(do_in), .den_out(den_out), .daddr_out(daddr_out),
    .raw_sample(raw_sample), .sample_valid(sample_valid),
    .ave_data(ave_data), .scaled_data(scaled_data),
    .ave_valid(ave_valid), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending-read flag, a wait counter and a queue
  // holding the current block's samples.
  bit       m_busy = 0;
  int       m_waited = 0;
  int       blk[$];
  bit       m_pend = 0;
  bit       e_den = 0, e_sv = 0, e_av = 0, e_terr = 0;
  int       e_raw = 0, e_ave = 0, e_scaled = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_waited = 0; blk.delete(); m_pend = 0;
      e_den = 0; e_sv = 0; e_av = 0; e_terr = 0;
      e_raw = 0; e_ave = 0; e_scaled = 0;
    end else begin
      e_den = 0; e_sv = 0; e_av = 0;
      if (m_pend) begin
        e_scaled = (e_ave * SM) / 65536;
        e_av = 1;
      end
      m_pend = 0;
      if (!m_busy) begin
        if (eoc_in) begin
          m_busy = 1; m_waited = 1; e_den = 1;
        end
      end else if (drdy_in) begin
        e_raw = int'(do_in) / 16;
        e_sv = 1;
        m_busy = 0;
        blk.push_back(e_raw);
        if (blk.size() == (1 << L)) begin
          int sum;
          sum = 0;
          foreach (blk[k]) sum += blk[k];
          e_ave = ((sum * 16) / (1 << L)) % 65536;
          m_pend = 1;
          blk.delete();
        end
      end else if (m_waited == TO) begin
        e_terr = 1; m_busy = 0;
      end else begin
        m_waited++;
      end
    end
  end

  always @(negedge clk) begin
    chk("den_out", 32'(den_out), 32'(e_den));
    chk("daddr_out", 32'(daddr_out), 32'h1F);
    chk("raw_sample", 32'(raw_sample), 32'(e_raw));
    chk("sample_valid", 32'(sample_valid), 32'(e_sv));
    chk("ave_data", 32'(ave_data), 32'(e_ave));
    chk("scaled_data", 32'(scaled_data), 32'(e_scaled));
    chk("ave_valid", 32'(ave_valid), 32'(e_av));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    if (den_out === 1'b1) den_cnt++;
    if (ave_valid === 1'b1) av_cnt++;
    if (sample_valid === 1'b1) sv_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] d, input int gap, input bit extra);
    eoc_in = 1'b1;
    cyc();
    eoc_in = 1'b0;
    for (int k = 0; k < gap; k++) begin
      eoc_in = (extra && k == 0);
      cyc();
    end
    eoc_in = 1'b0;
    drdy_in = 1'b1;
    do_in = d;
    cyc();
    drdy_in = 1'b0;
    do_in = 16'($urandom);
  endtask

  task automatic blk16(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ea, input logic [15:0] es);
    int a0;
    a0 = av_cnt;
    for (int i = 0; i < 16; i++) rd((i < 8) ? a : b, i % 4, 1'b0);
    chk("blk_ave_lit", 32'(ave_data), 32'(ea));
    chk("blk_av_early", 32'(ave_valid), 32'd0);
    cyc();
    chk("blk_av_lat2", 32'(ave_valid), 32'd1);
    chk("blk_scaled_lit", 32'(scaled_data), 32'(es));
    cyc();
    cyc();
    chk("blk_av_once", 32'(av_cnt - a0), 32'd1);
  endtask

  initial begin
    int d0;
    int s0;
    reset = 1'b1; eoc_in = 1'b0; drdy_in = 1'b0; do_in = '0;
    repeat (3) cyc();
    chk("rst_den", 32'(den_out), 32'd0);
    chk("rst_daddr", 32'(daddr_out), 32'h1F);
    chk("rst_ave", 32'(ave_data), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    cyc();

    // Single read with latency checks on den.
    d0 = den_cnt;
    eoc_in = 1'b1;
    cyc();
    eoc_in = 1'b0;
    chk("den_lat1", 32'(den_out), 32'd1);
    cyc();
    chk("den_width", 32'(den_out), 32'd0);
    cyc();
    cyc();
    drdy_in = 1'b1; do_in = 16'hABC0;
    cyc();
    drdy_in = 1'b0;
    chk("single_raw", 32'(raw_sample), 32'hABC);
    chk("single_sv", 32'(sample_valid), 32'd1);
    cyc();
    chk("single_sv_once", 32'(sample_valid), 32'd0);
    chk("single_den_cnt", 32'(den_cnt - d0), 32'd1);

    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    blk16(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'd999);
    blk16(16'h8000, 16'h8000, 16'h8000, 16'd500);
    blk16(16'h0000, 16'hFFF0, 16'h7FF8, 16'd499);

    // eoc during WAIT must not re-issue den; stray drdy in IDLE is ignored.
    d0 = den_cnt;
    rd(16'h1230, 5, 1'b1);
    cyc(); cyc();
    chk("eoc_in_wait", 32'(den_cnt - d0), 32'd1);
    s0 = sv_cnt;
    drdy_in = 1'b1; do_in = 16'h5550;
    cyc();
    drdy_in = 1'b0;
    cyc();
    chk("stray_drdy", 32'(sv_cnt - s0), 32'd0);

    // Timeout, then reads still need a full block.
    eoc_in = 1'b1; cyc(); eoc_in = 1'b0;
    repeat (260) cyc();
    chk("timeout_set", 32'(timeout_err), 32'd1);
    rd(16'h2220, 2, 1'b0);
    cyc();
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
    chk("after_to_raw", 32'(raw_sample), 32'h222);

    // drdy on the exact timeout edge is a sample.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    rd(16'h7770, TO - 1, 1'b0);
    cyc();
    chk("edge_drdy_terr", 32'(timeout_err), 32'd0);
    chk("edge_drdy_raw", 32'(raw_sample), 32'h777);

    // Reset squashes a pending ave_valid.
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    for (int i = 0; i < 16; i++) rd(16'h1000, 1, 1'b0);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("squash_av", 32'(ave_valid), 32'd0);
    chk("squash_ave", 32'(ave_data), 32'd0);
    cyc();

    // Reset mid-block discards the partial sum.
    for (int i = 0; i < 10; i++) rd(16'hFFF0, 0, 1'b0);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mid_rst_raw", 32'(raw_sample), 32'd0);
    chk("mid_rst_sv", 32'(sample_valid), 32'd0);
    cyc();
    blk16(16'h4000, 16'h4000, 16'h4000, 16'd250);

    // Randomized reads, checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = int'($urandom_range(0, 99));
      if (kind < 8) begin
        drdy_in = 1'b1; do_in = 16'($urandom);
        cyc();
        drdy_in = 1'b0;
      end else if (kind < 10) begin
        eoc_in = 1'b1; cyc(); eoc_in = 1'b0;
        repeat (TO + 2) cyc();
      end
      rd(16'($urandom), int'($urandom_range(0, 12)), kind[0]);
      if (kind > 60) repeat ($urandom_range(0, 3)) cyc();
    end
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
